// File: rtl/grapheme_mem_arb_pkg.sv
// Shared constants for the two-port frame-buffer arbiter: arbitration modes
// and the bit layout of the status word.
package grapheme_mem_arb_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int ST_UNDRFLW   = 0;
  localparam int ST_OVRFLW    = 1;
  localparam int ST_TAG_FULL  = 2;
  localparam int ST_LAST_PORT = 3;
  localparam int ST_LOCK_PORT = 4;
  localparam int ST_LOCK      = 5;
  localparam int ST_TAG_USED  = 8;

  // Smallest status width able to hold every field for a given tag depth.
  function automatic int status_min_w(input int depth);
    return ST_TAG_USED + $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/grapheme_mem_arb_tag_ff.sv
// Read-tag FIFO: remembers which port issued each outstanding read so that
// in-order returns can be routed back. First-word fall-through head.
module grapheme_mem_arb_tag_ff #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        push_tag,
  input  logic        pop,
  output logic        head_tag,
  output logic        empty,
  output logic        full,
  output logic [AW:0] used
);

  logic          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign used     = count;
  assign head_tag = mem_q[rd_ptr];

  // NOTE: storage is not reset; an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr] <= push_tag;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grapheme_mem_arb.sv
// Two-port arbiter in front of the frame-buffer controller: waitrequest-style
// grant with lock-until-accept, and tag-routed in-order read return.
module grapheme_mem_arb
  import grapheme_mem_arb_pkg::*;
#(
  parameter int MEM_DATA_W = 32,
  parameter int MEM_ADDR_W = 20,
  parameter int RD_TAG_D   = 16,
  parameter int ARB_MODE   = 0,
  parameter int STATUS_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_wren,
  input  logic                  p0_rden,
  input  logic [MEM_ADDR_W-1:0] p0_addr,
  input  logic [MEM_DATA_W-1:0] p0_wdata,
  output logic                  p0_wait,
  output logic                  p0_rd_valid,
  output logic [MEM_DATA_W-1:0] p0_rdata,
  input  logic                  p1_wren,
  input  logic                  p1_rden,
  input  logic [MEM_ADDR_W-1:0] p1_addr,
  input  logic [MEM_DATA_W-1:0] p1_wdata,
  output logic                  p1_wait,
  output logic                  p1_rd_valid,
  output logic [MEM_DATA_W-1:0] p1_rdata,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_wait,
  input  logic                  mem_rd_valid,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  input  logic                  clear_flags,
  output logic [STATUS_W-1:0]   status
);

  localparam int TAG_AW = $clog2(RD_TAG_D);

  logic          lock_r, lock_port_r, last_port_r;
  logic          ovrflw_r, undrflw_r;
  logic          req0, req1, elig0, elig1;
  logic          sel_valid, sel, accept;
  logic          tag_push, tag_head, tag_empty, tag_full;
  logic [TAG_AW:0] tag_used;
  logic          ret0, ret1;

  assign req0  = p0_wren | p0_rden;
  assign req1  = p1_wren | p1_rden;
  assign elig0 = req0 & (p0_wren | ~tag_full);
  assign elig1 = req1 & (p1_wren | ~tag_full);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel       = 1'b0;
    if (lock_r) begin
      sel_valid = 1'b1;
      sel       = lock_port_r;
    end else if (elig0 && elig1) begin
      sel_valid = 1'b1;
      sel       = (ARB_MODE == ARB_FIXED) ? 1'b0 : ~last_port_r;
    end else if (elig0) begin
      sel_valid = 1'b1;
      sel       = 1'b0;
    end else if (elig1) begin
      sel_valid = 1'b1;
      sel       = 1'b1;
    end
  end

  // A port asserting both strobes is treated as a write.
  always_comb begin
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel_valid) begin
      mem_wren  = sel ? p1_wren : p0_wren;
      mem_rden  = sel ? (p1_rden & ~p1_wren) : (p0_rden & ~p0_wren);
      mem_addr  = sel ? p1_addr  : p0_addr;
      mem_wdata = sel ? p1_wdata : p0_wdata;
    end
  end

  assign accept   = sel_valid & ~mem_wait;
  assign p0_wait  = req0 & ~(accept & ~sel);
  assign p1_wait  = req1 & ~(accept & sel);
  assign tag_push = accept & mem_rden;

  grapheme_mem_arb_tag_ff #(
    .DEPTH(RD_TAG_D)
  ) u_tag_ff (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_tag (sel),
    .pop      (mem_rd_valid),
    .head_tag (tag_head),
    .empty    (tag_empty),
    .full     (tag_full),
    .used     (tag_used)
  );

  assign ret0 = mem_rd_valid & ~tag_empty & ~tag_head;
  assign ret1 = mem_rd_valid & ~tag_empty &  tag_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r      <= 1'b0;
      lock_port_r <= 1'b0;
      last_port_r <= 1'b1;
      ovrflw_r    <= 1'b0;
      undrflw_r   <= 1'b0;
      p0_rd_valid <= 1'b0;
      p1_rd_valid <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      if (accept) begin
        lock_r      <= 1'b0;
        last_port_r <= sel;
      end else if (sel_valid) begin
        lock_r      <= 1'b1;
        lock_port_r <= sel;
      end
      // Set has priority over a same-cycle clear.
      ovrflw_r    <= (tag_push & tag_full) | (ovrflw_r & ~clear_flags);
      undrflw_r   <= (mem_rd_valid & tag_empty) | (undrflw_r & ~clear_flags);
      p0_rd_valid <= ret0;
      p1_rd_valid <= ret1;
      if (ret0) p0_rdata <= mem_rdata;
      if (ret1) p1_rdata <= mem_rdata;
    end
  end

  always_comb begin
    status                              = '0;
    status[ST_UNDRFLW]                  = undrflw_r;
    status[ST_OVRFLW]                   = ovrflw_r;
    status[ST_TAG_FULL]                 = tag_full;
    status[ST_LAST_PORT]                = last_port_r;
    status[ST_LOCK_PORT]                = lock_port_r;
    status[ST_LOCK]                     = lock_r;
    status[ST_TAG_USED +: TAG_AW+1]     = tag_used;
  end

endmodule

// File: tb/tb_grapheme_mem_arb.sv
// Bench for grapheme_mem_arb: table-driven request-path vectors, a controller
// model with a read-return scoreboard, and hand-written corner sequences.
module tb_grapheme_mem_arb;
  import grapheme_mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int TD = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_wren, p0_rden, p1_wren, p1_rden;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_wait, p1_wait, p0_rd_valid, p1_rd_valid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_wren, mem_rden, mem_wait, mem_rd_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          clear_flags;
  logic [31:0]   status;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } rd_exp_t;
  rd_exp_t exp_q[$];
  rd_exp_t mon_e;

  typedef struct {
    logic          p0_wr;
    logic [AW-1:0] p0_a;
    logic [DW-1:0] p0_d;
    logic          p1_wr;
    logic [AW-1:0] p1_a;
    logic [DW-1:0] p1_d;
    logic          wt;
    logic          e_wren;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_w0;
    logic          e_w1;
  } vec_t;
  vec_t vecs[9];

  // Controller model state
  logic          model_en;
  logic          inject;
  logic [DW-1:0] inject_data;
  logic [2:0]    pipe_v;
  logic [AW-1:0] pipe_a [3];
  logic          acc;
  logic [AW-1:0] acc_a;

  grapheme_mem_arb #(
    .MEM_DATA_W(DW), .MEM_ADDR_W(AW), .RD_TAG_D(TD), .ARB_MODE(0), .STATUS_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_wren(p0_wren), .p0_rden(p0_rden), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wait(p0_wait), .p0_rd_valid(p0_rd_valid), .p0_rdata(p0_rdata),
    .p1_wren(p1_wren), .p1_rden(p1_rden), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wait(p1_wait), .p1_rd_valid(p1_rd_valid), .p1_rdata(p1_rdata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wait(mem_wait), .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata),
    .clear_flags(clear_flags), .status(status)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return {12'hC0D, a} ^ 32'h0005_A5A5;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_wren = 0; p0_rden = 0; p0_addr = '0; p0_wdata = '0;
    p1_wren = 0; p1_rden = 0; p1_addr = '0; p1_wdata = '0;
    mem_wait = 0; clear_flags = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Controller model: reads accepted at an edge return three cycles later.
  initial begin
    pipe_v = '0;
    mem_rd_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      acc   = model_en & mem_rden & ~mem_wait;
      acc_a = mem_addr;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pipe_v = '0;
      end else begin
        pipe_v    = {pipe_v[1:0], acc};
        pipe_a[2] = pipe_a[1];
        pipe_a[1] = pipe_a[0];
        pipe_a[0] = acc_a;
      end
      mem_rd_valid = pipe_v[2] | inject;
      mem_rdata    = inject ? inject_data : (pipe_v[2] ? rd_fn(pipe_a[2]) : '0);
      inject       = 1'b0;
    end
  end

  // Return monitor: every read-valid pulse must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (p0_rd_valid || p1_rd_valid)) begin
        if (p0_rd_valid && p1_rd_valid)
          check("rd_valid_both", 64'({p1_rd_valid, p0_rd_valid}), 64'(2'b01));
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 64'({p1_rd_valid, p0_rd_valid}), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_port", 64'(p1_rd_valid), 64'(mon_e.port));
          check("rd_data", 64'(p1_rd_valid ? p1_rdata : p0_rdata), 64'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1;
    logic g;
    inject = 1'b0;
    inject_data = '0;
    model_en = 1'b0;
    rst_n = 1'b1;
    idle_inputs();

    vecs[0] = '{0, 20'h0, 32'h0, 0, 20'h0, 32'h0, 0,  0, 20'h0, 32'h0, 0, 0};
    vecs[1] = '{1, 20'h12345, 32'hAABBCCDD, 0, 20'h0, 32'h0, 0,  1, 20'h12345, 32'hAABBCCDD, 0, 0};
    vecs[2] = '{1, 20'h1, 32'h11111111, 1, 20'h2, 32'h22222222, 0,  1, 20'h2, 32'h22222222, 1, 0};
    vecs[3] = '{1, 20'h1, 32'h11111111, 1, 20'h2, 32'h22222222, 0,  1, 20'h1, 32'h11111111, 0, 1};
    vecs[4] = '{1, 20'h1, 32'h11111111, 1, 20'h2, 32'h22222222, 1,  1, 20'h2, 32'h22222222, 1, 1};
    vecs[5] = '{1, 20'h1, 32'h11111111, 1, 20'h2, 32'h22222222, 0,  1, 20'h2, 32'h22222222, 1, 0};
    vecs[6] = '{0, 20'h0, 32'h0, 1, 20'h2, 32'h22222222, 0,  1, 20'h2, 32'h22222222, 0, 0};
    vecs[7] = '{1, 20'h1, 32'h11111111, 1, 20'h2, 32'h22222222, 0,  1, 20'h1, 32'h11111111, 0, 1};
    vecs[8] = '{0, 20'h0, 32'h0, 0, 20'h0, 32'h0, 0,  0, 20'h0, 32'h0, 0, 0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset_status", 64'(status), 64'(32'h8));
    check("reset_rd", 64'({p0_rd_valid, p1_rd_valid, p0_rdata[15:0], p1_rdata[15:0]}), 64'(0));
    check("reset_mem", 64'({mem_wren, mem_rden, mem_addr, mem_wdata, p0_wait, p1_wait}), 64'(0));
    tick();

    // Request path, round-robin and lock, from a table
    for (int i = 0; i < 9; i++) begin
      p0_wren = vecs[i].p0_wr; p0_addr = vecs[i].p0_a; p0_wdata = vecs[i].p0_d;
      p1_wren = vecs[i].p1_wr; p1_addr = vecs[i].p1_a; p1_wdata = vecs[i].p1_d;
      mem_wait = vecs[i].wt;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            64'({mem_wren, mem_rden, mem_addr, mem_wdata, p0_wait, p1_wait}),
            64'({vecs[i].e_wren, 1'b0, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_w0, vecs[i].e_w1}));
      tick();
    end

    // Both ports read every cycle: grants alternate 0,1,0,1 and data returns per port
    do_reset();
    model_en = 1'b1;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 8; c++) begin
      g = c[0];
      p0_rden = 1; p0_addr = 20'h100 + 20'(n0);
      p1_rden = 1; p1_addr = 20'h200 + 20'(n1);
      exp_q.push_back('{g, rd_fn(g ? p1_addr : p0_addr)});
      @(negedge clk);
      check($sformatf("alt%0d", c), 64'({mem_rden, mem_addr, p0_wait, p1_wait}),
            64'({1'b1, (g ? p1_addr : p0_addr), g, ~g}));
      if (g) n1++; else n0++;
      tick();
    end
    idle_inputs();
    repeat (6) tick();
    check("alt_drain", 64'(exp_q.size()), 64'(0));

    // Lock: p1 held off by mem_wait while p0 also requests
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      mem_wait = (c <= 4);
      p1_wren = (c <= 5); p1_addr = 20'h333; p1_wdata = 32'h33333333;
      p0_wren = (c >= 2); p0_addr = 20'h111; p0_wdata = 32'h11111111;
      @(negedge clk);
      if (c <= 5)
        check($sformatf("lock%0d", c), 64'({mem_addr, p0_wait, p1_wait}),
              64'({20'h333, (c >= 2), (c <= 4)}));
      else
        check("lock6", 64'({mem_addr, p0_wait, p1_wait}), 64'({20'h111, 1'b0, 1'b0}));
      if (c == 3) check("lock_status", 64'(status[5:3]), 64'(3'b111));
      tick();
    end
    idle_inputs();

    // Tag FIFO full: 17th read blocked, write still passes, one return frees it
    do_reset();
    for (int i = 0; i < TD; i++) begin
      p1_rden = 1; p1_addr = 20'h400 + 20'(i);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("full_status", 64'(status), 64'(32'h100C));
    tick();
    p1_rden = 1; p1_addr = 20'h410;
    p0_wren = 1; p0_addr = 20'h500; p0_wdata = 32'h55;
    @(negedge clk);
    check("full_rd_blocked", 64'({mem_wren, mem_rden, mem_addr, p0_wait, p1_wait}),
          64'({1'b1, 1'b0, 20'h500, 1'b0, 1'b1}));
    tick();
    p0_wren = 0;
    inject = 1; inject_data = 32'h1234ABCD;
    exp_q.push_back('{1'b1, 32'h1234ABCD});
    @(negedge clk);
    check("full_pop_same_cycle", 64'({mem_rden, p1_wait}), 64'({1'b0, 1'b1}));
    tick();
    @(negedge clk);
    check("full_released", 64'({mem_rden, mem_addr, p1_wait}), 64'({1'b1, 20'h410, 1'b0}));
    tick();
    idle_inputs();
    tick();
    check("full_ret_seen", 64'(exp_q.size()), 64'(0));

    // Underflow flag, clear, and set-beats-clear
    do_reset();
    inject = 1; inject_data = 32'hDEADBEEF;
    tick();
    @(negedge clk);
    check("undrflw_set", 64'(status[1:0]), 64'(2'b01));
    tick();
    clear_flags = 1;
    tick();
    clear_flags = 0;
    @(negedge clk);
    check("undrflw_clear", 64'(status[1:0]), 64'(2'b00));
    tick();
    clear_flags = 1; inject = 1;
    tick();
    clear_flags = 0;
    @(negedge clk);
    check("undrflw_set_wins", 64'(status[0]), 64'(1));
    tick();

    // Reset with reads outstanding and a lock held
    do_reset();
    for (int i = 0; i < 3; i++) begin
      p0_rden = 1; p0_addr = 20'h600 + 20'(i);
      tick();
    end
    p0_addr = 20'h603; mem_wait = 1;
    tick();
    @(negedge clk);
    check("pre_reset_status", 64'(status), 64'(32'h320));
    tick();
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    check("in_reset_status", 64'(status), 64'(32'h8));
    rst_n = 1;
    tick();
    inject = 1; inject_data = 32'h0BAD0BAD;
    tick();
    @(negedge clk);
    check("post_reset_undrflw", 64'(status), 64'(32'h9));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
